dec_8b_10b_sched: RTL and testbench

Round-robin scheduler that shares one 8b/10b decoder wrapper between `PORTCOUNT` receive lanes in the PHY. Each lane offers an encoded flit through a valid/ready handshake. The scheduler grants one lane at a time and drives the decoder's switch-side signals. It waits for `done_out`, then returns the decoded flit, comma select and error flag to the granted lane. An optional watchdog recovers from a decoder that never completes.

---
 rtl/dec_8b_10b_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_dec_8b_10b_sched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_8b_10b_sched.sv
// dec_8b_10b_sched: round-robin arbiter that time-shares one 8b/10b decoder
// wrapper between PORTCOUNT receive lanes. One lane is granted at a time. Its
// flit is issued to the decoder with a one-cycle start pulse. The decoded result
// is returned to that lane as a one-cycle response pulse.
// Optional feature macro: DEC_SCHED_TIMEOUT_EN adds a WAIT-state watchdog that
// forces an error response after TIMEOUT cycles without dec_done_out.
module dec_8b_10b_sched #(
  parameter int PORTCOUNT = 5,
  parameter int TIMEOUT   = 64,
  parameter int ENC_W     = 10,
  parameter int FLIT_W    = 8,
  parameter int CLS_W     = 2,
  parameter int CS_W      = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [PORTCOUNT-1:0]             req_valid,
  input  logic [PORTCOUNT-1:0][ENC_W-1:0]  req_enc_flit,
  input  logic [PORTCOUNT-1:0][CLS_W-1:0]  req_comma_length_sel,
  input  logic [PORTCOUNT-1:0]             req_err,
  output logic [PORTCOUNT-1:0]             req_ready,
  output logic [PORTCOUNT-1:0]             rsp_valid,
  output logic [FLIT_W-1:0]                rsp_flit,
  output logic [CS_W-1:0]                  rsp_comma_sel,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [ENC_W-1:0]                 dec_enc_flit,
  output logic                             dec_done,
  output logic [CLS_W-1:0]                 dec_comma_length_sel,
  output logic                             dec_err,
  input  logic [FLIT_W-1:0]                dec_flit,
  input  logic [CS_W-1:0]                  dec_comma_sel,
  input  logic                             dec_done_out,
  input  logic                             dec_err_out,
  output logic                             busy
);

  localparam int PTR_W = (PORTCOUNT > 1) ? $clog2(PORTCOUNT) : 1;
  localparam logic [PORTCOUNT-1:0] LANE0_ONEHOT = {{(PORTCOUNT-1){1'b0}}, 1'b1};

  // Reject configurations outside the supported lane range.
  if (PORTCOUNT < 2 || PORTCOUNT > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("dec_8b_10b_sched: unsupported PORTCOUNT/TIMEOUT");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [PTR_W-1:0]       rr_ptr_r, lane_r, gnt_idx_s, rr_next_s;
  logic                   gnt_found_s;
  int                     idx_v;
  logic [ENC_W-1:0]       enc_r;
  logic [CLS_W-1:0]       cls_r;
  logic                   err_r, done_r;
  logic [PORTCOUNT-1:0]   rsp_valid_r;
  logic [FLIT_W-1:0]      rsp_flit_r;
  logic [CS_W-1:0]        rsp_cs_r;
  logic                   rsp_err_r, rsp_to_r;
  logic                   res_take_s, res_to_s, timeout_hit_s;

`ifdef DEC_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_r;

  // Watchdog count of WAIT cycles; restarts every time ISSUE hands over to WAIT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ISSUE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == WAIT && cnt_r != CNT_W'(TIMEOUT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Round-robin search: first valid lane at or above rr_ptr, wrapping around.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = {PTR_W{1'b0}};
    idx_v       = 0;
    for (int k = 0; k < PORTCOUNT; k++) begin
      idx_v = int'(rr_ptr_r) + k;
      if (idx_v >= PORTCOUNT) begin
        idx_v = idx_v - PORTCOUNT;
      end else begin
        idx_v = idx_v;
      end
      if (!gnt_found_s && req_valid[idx_v]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = PTR_W'(idx_v);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    if (gnt_idx_s == PTR_W'(PORTCOUNT - 1)) begin
      rr_next_s = {PTR_W{1'b0}};
    end else begin
      rr_next_s = gnt_idx_s + PTR_W'(1);
    end
  end

  // Accept handshake is combinational so a lane learns of its grant in the grant cycle.
  always_comb begin
    req_ready = {PORTCOUNT{1'b0}};
    if (state_r == IDLE && gnt_found_s) begin
      req_ready = LANE0_ONEHOT << gnt_idx_s;
    end else begin
      req_ready = {PORTCOUNT{1'b0}};
    end
  end

  // Result events: done_out counts in ISSUE too (combinational decoder), never in IDLE/RESP.
  always_comb begin
    res_take_s = 1'b0;
    res_to_s   = 1'b0;
    if (state_r == ISSUE || state_r == WAIT) begin
      res_take_s = dec_done_out;
      res_to_s   = (state_r == WAIT) && !dec_done_out && timeout_hit_s;
    end else begin
      res_take_s = 1'b0;
      res_to_s   = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> (WAIT) -> RESP cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_found_s) state_s = ISSUE;
        else             state_s = IDLE;
      end
      ISSUE: begin
        if (dec_done_out) state_s = RESP;
        else              state_s = WAIT;
      end
      WAIT: begin
        if (dec_done_out || timeout_hit_s) state_s = RESP;
        else                               state_s = WAIT;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Grant capture: latch the lane's request, advance rr_ptr, raise the start pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_r <= {PTR_W{1'b0}};
      lane_r   <= {PTR_W{1'b0}};
      enc_r    <= {ENC_W{1'b0}};
      cls_r    <= {CLS_W{1'b0}};
      err_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_found_s) begin
            rr_ptr_r <= rr_next_s;
            lane_r   <= gnt_idx_s;
            enc_r    <= req_enc_flit[gnt_idx_s];
            cls_r    <= req_comma_length_sel[gnt_idx_s];
            err_r    <= req_err[gnt_idx_s];
            done_r   <= 1'b1;
          end
        end
        RESP: begin
          lane_r <= {PTR_W{1'b0}};
          enc_r  <= {ENC_W{1'b0}};
          cls_r  <= {CLS_W{1'b0}};
          err_r  <= 1'b0;
          done_r <= 1'b0;
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  // Response register: loaded on the result event so it is visible for the RESP cycle only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid_r <= {PORTCOUNT{1'b0}};
      rsp_flit_r  <= {FLIT_W{1'b0}};
      rsp_cs_r    <= {CS_W{1'b0}};
      rsp_err_r   <= 1'b0;
      rsp_to_r    <= 1'b0;
    end else if (res_take_s) begin
      rsp_valid_r <= LANE0_ONEHOT << lane_r;
      rsp_flit_r  <= dec_flit;
      rsp_cs_r    <= dec_comma_sel;
      rsp_err_r   <= dec_err_out;
      rsp_to_r    <= 1'b0;
    end else if (res_to_s) begin
      rsp_valid_r <= LANE0_ONEHOT << lane_r;
      rsp_flit_r  <= {FLIT_W{1'b0}};
      rsp_cs_r    <= {CS_W{1'b0}};
      rsp_err_r   <= 1'b1;
      rsp_to_r    <= 1'b1;
    end else begin
      rsp_valid_r <= {PORTCOUNT{1'b0}};
      rsp_flit_r  <= {FLIT_W{1'b0}};
      rsp_cs_r    <= {CS_W{1'b0}};
      rsp_err_r   <= 1'b0;
      rsp_to_r    <= 1'b0;
    end
  end

  assign rsp_valid            = rsp_valid_r;
  assign rsp_flit             = rsp_flit_r;
  assign rsp_comma_sel        = rsp_cs_r;
  assign rsp_err              = rsp_err_r;
  assign rsp_timeout          = rsp_to_r;
  assign dec_enc_flit         = enc_r;
  assign dec_done             = done_r;
  assign dec_comma_length_sel = cls_r;
  assign dec_err              = err_r;
  assign busy                 = (state_r != IDLE);

endmodule

// File: tb/tb_dec_8b_10b_sched.sv
// Directed testbench for dec_8b_10b_sched (5 lanes, TIMEOUT=8). The decoder is
// modelled in the bench: flit = enc[7:0]^8'h5A, comma_sel = enc[9:8]^comma_length_sel,
// with done_out delayed dec_lat cycles after done (0 = combinational).
module tb_dec_8b_10b_sched;

  localparam int PC = 5;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [PC-1:0]    req_valid;
  logic [PC-1:0][9:0] req_enc_flit;
  logic [PC-1:0][1:0] req_cls;
  logic [PC-1:0]    req_err;
  logic [PC-1:0]    req_ready, rsp_valid;
  logic [7:0]       rsp_flit;
  logic [1:0]       rsp_comma_sel;
  logic             rsp_err, rsp_timeout;
  logic [9:0]       dec_enc_flit;
  logic             dec_done;
  logic [1:0]       dec_comma_length_sel;
  logic             dec_err;
  logic [7:0]       dec_flit;
  logic [1:0]       dec_comma_sel;
  logic             dec_done_out, dec_err_out;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  logic [9:0] lane_enc [PC] = '{10'h2C3, 10'h15A, 10'h3E7, 10'h0B4, 10'h1F0};
  logic [1:0] lane_cls [PC] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
  logic [PC-1:0] lane_err = 5'b01010;

  // decoder model
  logic [15:0] done_pipe = 16'd0;
  logic        dec_en;
  int          dec_lat;
  logic        dec_err_inj;

  always @(posedge clk) begin
    cyc_cnt   <= cyc_cnt + 1;
    done_pipe <= {done_pipe[14:0], dec_done};
  end

  always_comb begin
    dec_done_out = 1'b0;
    if (dec_en) begin
      if (dec_lat == 0) dec_done_out = dec_done;
      else              dec_done_out = done_pipe[4'(dec_lat - 1)];
    end else begin
      dec_done_out = 1'b0;
    end
  end

  assign dec_flit      = dec_enc_flit[7:0] ^ 8'h5A;
  assign dec_comma_sel = dec_enc_flit[9:8] ^ dec_comma_length_sel;
  assign dec_err_out   = dec_err_inj;

  logic [36:0] all_out;
  assign all_out = {req_ready, rsp_valid, rsp_flit, rsp_comma_sel, rsp_err, rsp_timeout,
                    dec_enc_flit, dec_done, dec_comma_length_sel, dec_err, busy};

  dec_8b_10b_sched #(.PORTCOUNT(PC), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_enc_flit(req_enc_flit),
    .req_comma_length_sel(req_cls), .req_err(req_err),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_flit(rsp_flit),
    .rsp_comma_sel(rsp_comma_sel), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .dec_enc_flit(dec_enc_flit), .dec_done(dec_done),
    .dec_comma_length_sel(dec_comma_length_sel), .dec_err(dec_err),
    .dec_flit(dec_flit), .dec_comma_sel(dec_comma_sel),
    .dec_done_out(dec_done_out), .dec_err_out(dec_err_out), .busy(busy)
  );

  function automatic logic [7:0] exp_flit(input int l);
    logic [9:0] e;
    e = lane_enc[l];
    return e[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [1:0] exp_cs(input int l);
    logic [9:0] e;
    e = lane_enc[l];
    return e[9:8] ^ lane_cls[l];
  endfunction

  function automatic int onehot_idx(input logic [PC-1:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < PC; i++) begin
      if (v[i]) begin r = i; n++; end
    end
    if (n > 1) r = -2;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  // Waits (bounded) for a grant; lane = -1 when the budget expires.
  task automatic wait_grant(input int budget, output int lane, output int at);
    bit hit = 1'b0;
    lane = -1;
    at   = -1;
    for (int c = 0; c < budget && !hit; c++) begin
      #1;
      if (req_ready != 5'b00000) begin
        lane = onehot_idx(req_ready);
        at   = cyc_cnt;
        hit  = 1'b1;
      end else begin
        tick;
      end
    end
  endtask

  // Waits (bounded) for a response pulse; mask = 0 when the budget expires.
  task automatic wait_rsp(input int budget, output logic [PC-1:0] mask);
    bit hit = 1'b0;
    mask = 5'b00000;
    for (int c = 0; c < budget && !hit; c++) begin
      #1;
      if (rsp_valid != 5'b00000) begin
        mask = rsp_valid;
        hit  = 1'b1;
      end else begin
        tick;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    #1;
    n_checks++;
    if (all_out !== 37'd0) $display("FAIL reset_outputs: got %0h expected 0", all_out);
    if (all_out !== 37'd0) n_fail++;
    rst = 1'b0;
    tick;
    #1;
    n_checks++;
    if ({busy, req_ready} !== 6'd0) begin
      $display("FAIL idle_no_request: busy/req_ready got %0h expected 0", {busy, req_ready});
      n_fail++;
    end
  endtask

  task automatic test_single;
    dec_en = 1'b1; dec_lat = 3; dec_err_inj = 1'b0;
    req_valid = 5'b00100;
    #1;
    n_checks++;
    if (req_ready !== 5'b00100) begin
      $display("FAIL single_ready: got %b expected 00100", req_ready); n_fail++;
    end
    tick; req_valid = 5'b00000; #1;
    n_checks++;
    if ({dec_done, dec_enc_flit, dec_comma_length_sel, dec_err, busy} !==
        {1'b1, lane_enc[2], lane_cls[2], lane_err[2], 1'b1}) begin
      $display("FAIL single_issue: got %0h expected %0h",
               {dec_done, dec_enc_flit, dec_comma_length_sel, dec_err, busy},
               {1'b1, lane_enc[2], lane_cls[2], lane_err[2], 1'b1});
      n_fail++;
    end
    for (int k = 2; k <= 4; k++) begin
      tick; #1;
      n_checks++;
      if (rsp_valid !== 5'b00000 || dec_done !== 1'b0) begin
        $display("FAIL single_wait_T%0d: rsp_valid %b dec_done %b expected 0", k, rsp_valid, dec_done);
        n_fail++;
      end
    end
    tick; #1;
    n_checks++;
    if ({rsp_valid, rsp_flit, rsp_comma_sel, rsp_err, rsp_timeout} !==
        {5'b00100, exp_flit(2), exp_cs(2), 1'b0, 1'b0}) begin
      $display("FAIL single_rsp: got %0h expected %0h",
               {rsp_valid, rsp_flit, rsp_comma_sel, rsp_err, rsp_timeout},
               {5'b00100, exp_flit(2), exp_cs(2), 1'b0, 1'b0});
      n_fail++;
    end
    tick; #1;
    n_checks++;
    if (all_out !== 37'd0) begin
      $display("FAIL single_back_idle: got %0h expected 0", all_out); n_fail++;
    end
  endtask

  task automatic test_round_robin;
    int lane, at, prev;
    do_reset;
    dec_en = 1'b1; dec_lat = 1; dec_err_inj = 1'b0;
    req_valid = 5'b11111;
    prev = 0;
    for (int g = 0; g < 6; g++) begin
      wait_grant(12, lane, at);
      n_checks++;
      if (lane !== (g % PC)) begin
        $display("FAIL rr_order_%0d: got lane %0d expected %0d", g, lane, g % PC); n_fail++;
      end
      if (g > 0) begin
        n_checks++;
        if (at - prev !== 4) begin
          $display("FAIL rr_spacing_%0d: got %0d expected 4", g, at - prev); n_fail++;
        end
      end
      prev = at;
      tick;
    end
    req_valid = 5'b00000;
    repeat (5) tick;
  endtask

  task automatic test_rr_wrap;
    int lane, at;
    do_reset;
    dec_en = 1'b1; dec_lat = 0; dec_err_inj = 1'b0;
    req_valid = 5'b00010;
    wait_grant(4, lane, at);
    n_checks++;
    if (lane !== 1) begin $display("FAIL wrap_first: got %0d expected 1", lane); n_fail++; end
    tick; req_valid = 5'b00000;
    tick; #1;
    n_checks++;
    if ({rsp_valid, rsp_flit, rsp_err} !== {5'b00010, exp_flit(1), 1'b0}) begin
      $display("FAIL comb_decoder_rsp: got %0h expected %0h",
               {rsp_valid, rsp_flit, rsp_err}, {5'b00010, exp_flit(1), 1'b0});
      n_fail++;
    end
    tick;
    req_valid = 5'b01001;
    wait_grant(6, lane, at);
    n_checks++;
    if (lane !== 3) begin $display("FAIL wrap_after_ptr2: got %0d expected 3", lane); n_fail++; end
    tick; req_valid = 5'b00001;
    wait_grant(8, lane, at);
    n_checks++;
    if (lane !== 0) begin $display("FAIL wrap_to_lane0: got %0d expected 0", lane); n_fail++; end
    tick; req_valid = 5'b00000;
    repeat (4) tick;
  endtask

  task automatic test_dec_err;
    int lane, at;
    logic [PC-1:0] m;
    dec_en = 1'b1; dec_lat = 2; dec_err_inj = 1'b1;
    req_valid = 5'b10000;
    wait_grant(6, lane, at);
    tick; req_valid = 5'b00000;
    wait_rsp(10, m);
    n_checks++;
    if ({m, rsp_flit, rsp_err, rsp_timeout} !== {5'b10000, exp_flit(4), 1'b1, 1'b0}) begin
      $display("FAIL dec_err_rsp: got %0h expected %0h",
               {m, rsp_flit, rsp_err, rsp_timeout}, {5'b10000, exp_flit(4), 1'b1, 1'b0});
      n_fail++;
    end
    dec_err_inj = 1'b0;
    tick;
    req_valid = 5'b00001;
    wait_grant(6, lane, at);
    n_checks++;
    if (lane !== 0) begin $display("FAIL after_err_grant: got %0d expected 0", lane); n_fail++; end
    tick; req_valid = 5'b00000;
    wait_rsp(10, m);
    n_checks++;
    if ({m, rsp_flit, rsp_err} !== {5'b00001, exp_flit(0), 1'b0}) begin
      $display("FAIL after_err_rsp: got %0h expected %0h",
               {m, rsp_flit, rsp_err}, {5'b00001, exp_flit(0), 1'b0});
      n_fail++;
    end
    repeat (3) tick;
  endtask

  task automatic test_rst_mid;
    int lane, at;
    int bad;
    do_reset;
    dec_en = 1'b1; dec_lat = 6; dec_err_inj = 1'b0;
    req_valid = 5'b00100;
    wait_grant(4, lane, at);
    tick; req_valid = 5'b00000;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    n_checks++;
    if (all_out !== 37'd0) begin $display("FAIL mid_reset_outputs: got %0h expected 0", all_out); n_fail++; end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick; #1;
      if (all_out !== 37'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin $display("FAIL mid_reset_no_rsp: got %0d active cycles expected 0", bad); n_fail++; end
    req_valid = 5'b01010;
    wait_grant(4, lane, at);
    n_checks++;
    if (lane !== 1) begin $display("FAIL mid_reset_ptr: got lane %0d expected 1", lane); n_fail++; end
    tick; req_valid = 5'b00000;
    repeat (10) tick;
  endtask

`ifdef DEC_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int lane, at;
    int early;
    for (int pass = 0; pass < 2; pass++) begin
      dec_en = (pass == 1); dec_lat = 9; dec_err_inj = 1'b0;
      req_valid = 5'b00001;
      wait_grant(6, lane, at);
      tick; req_valid = 5'b00000;
      early = 0;
      for (int k = 2; k <= 10; k++) begin
        tick; #1;
        if (rsp_valid !== 5'b00000) early++;
      end
      n_checks++;
      if (early !== 0) begin $display("FAIL timeout_early_%0d: got %0d expected 0", pass, early); n_fail++; end
      tick; #1;
      n_checks++;
      if (pass == 0 && {rsp_valid, rsp_flit, rsp_comma_sel, rsp_err, rsp_timeout} !==
                       {5'b00001, 8'h00, 2'b00, 1'b1, 1'b1}) begin
        $display("FAIL timeout_rsp: got %0h expected %0h",
                 {rsp_valid, rsp_flit, rsp_comma_sel, rsp_err, rsp_timeout},
                 {5'b00001, 8'h00, 2'b00, 1'b1, 1'b1});
        n_fail++;
      end
      if (pass == 1 && {rsp_valid, rsp_flit, rsp_err, rsp_timeout} !==
                       {5'b00001, exp_flit(0), 1'b0, 1'b0}) begin
        $display("FAIL done_wins_rsp: got %0h expected %0h",
                 {rsp_valid, rsp_flit, rsp_err, rsp_timeout}, {5'b00001, exp_flit(0), 1'b0, 1'b0});
        n_fail++;
      end
      tick; #1;
      n_checks++;
      if (busy !== 1'b0) begin $display("FAIL timeout_idle_%0d: busy got %b expected 0", pass, busy); n_fail++; end
      repeat (12) tick;
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = 5'b00000;
    req_err = lane_err;
    for (int i = 0; i < PC; i++) begin
      req_enc_flit[i] = lane_enc[i];
      req_cls[i]      = lane_cls[i];
    end
    dec_en = 1'b1; dec_lat = 0; dec_err_inj = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_rr_wrap;
    test_dec_err;
    test_rst_mid;
`ifdef DEC_SCHED_TIMEOUT_EN
    test_timeout;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

endmodule
